// File: rtl/spi_frame_ctrl.sv
// SPI slave frame engine in the SCLK domain: decodes cmd/addr/data frames,
// shifts read data out on MISO and publishes toggle events to the bus bridge.
module spi_frame_ctrl #(
  parameter int ADDR_W    = 24,
  parameter int DUMMY_CYC = 8
) (
  input  logic              sclk_i,
  input  logic              rst_ni,
  input  logic              ss_ni,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic              wr_tgl_o,
  output logic              rd_tgl_o,
  input  logic [31:0]       rdata_i,
  output logic              frame_err_o
);

  localparam int SR_W    = (ADDR_W > 32) ? ADDR_W : 32;
  localparam int MAX_CNT = (SR_W > DUMMY_CYC) ? SR_W : DUMMY_CYC;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [2:0] ST_CMD    = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_WDATA  = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  logic [2:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [SR_W-1:0]  rx_sr;
  logic [SR_W-1:0]  rx_next;
  logic             is_read;
  logic             first_word;
  logic [31:0]      tx_sr;

  logic last_cmd, last_addr, last_word, last_dummy;

  assign rx_next    = {rx_sr[SR_W-2:0], mosi_i};
  assign last_cmd   = (bit_cnt == CNT_W'(7));
  assign last_addr  = (bit_cnt == CNT_W'(ADDR_W - 1));
  assign last_word  = (bit_cnt == CNT_W'(31));
  assign last_dummy = (bit_cnt == CNT_W'(DUMMY_CYC - 1));

  // Frame state: raising ss_ni aborts the frame asynchronously.
  always_ff @(posedge sclk_i or negedge rst_ni or posedge ss_ni) begin
    if (!rst_ni) begin
      state       <= ST_CMD;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      is_read     <= 1'b0;
      first_word  <= 1'b1;
      frame_err_o <= 1'b0;
    end else if (ss_ni) begin
      state       <= ST_CMD;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      is_read     <= 1'b0;
      first_word  <= 1'b1;
      frame_err_o <= 1'b0;
    end else begin
      rx_sr   <= rx_next;
      bit_cnt <= bit_cnt + CNT_W'(1);
      case (state)
        ST_CMD: begin
          if (last_cmd) begin
            bit_cnt <= '0;
            if (rx_next[7:0] == CMD_WRITE) begin
              state   <= ST_ADDR;
              is_read <= 1'b0;
            end else if (rx_next[7:0] == CMD_READ) begin
              state   <= ST_ADDR;
              is_read <= 1'b1;
            end else begin
              state       <= ST_IGNORE;
              frame_err_o <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (last_addr) begin
            bit_cnt <= '0;
            state   <= is_read ? ST_DUMMY : ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (last_word) begin
            bit_cnt    <= '0;
            first_word <= 1'b0;
          end
        end
        ST_DUMMY: begin
          if (last_dummy) begin
            bit_cnt <= '0;
            state   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (last_word) begin
            bit_cnt <= '0;
            state   <= ST_DUMMY;
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

  // Event outputs survive a frame abort so the bridge never sees a glitch.
  always_ff @(posedge sclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_o   <= '0;
      wdata_o  <= '0;
      wr_tgl_o <= 1'b0;
      rd_tgl_o <= 1'b0;
    end else if (!ss_ni) begin
      if (state == ST_ADDR && last_addr) begin
        addr_o <= rx_next[ADDR_W-1:0];
        if (is_read) rd_tgl_o <= ~rd_tgl_o;
      end else if (state == ST_WDATA && last_word) begin
        wdata_o  <= rx_next[31:0];
        wr_tgl_o <= ~wr_tgl_o;
        if (!first_word) addr_o <= addr_o + ADDR_W'(4);
      end else if (state == ST_RDATA && last_word) begin
        addr_o   <= addr_o + ADDR_W'(4);
        rd_tgl_o <= ~rd_tgl_o;
      end
    end
  end

  // Read data is loaded on the first fall of RDATA, then shifted each fall.
  always_ff @(negedge sclk_i or negedge rst_ni or posedge ss_ni) begin
    if (!rst_ni) begin
      tx_sr <= '0;
    end else if (ss_ni) begin
      tx_sr <= '0;
    end else if (state == ST_RDATA) begin
      if (bit_cnt == '0) tx_sr <= rdata_i;
      else               tx_sr <= {tx_sr[30:0], 1'b0};
    end else begin
      tx_sr <= '0;
    end
  end

  assign miso_o = tx_sr[31];

endmodule
